// File: rtl/aes_round_key_stage.sv
// -----------------------------------------------------------------------------
// aes_round_key_stage
//
// AddRoundKey stage and round sequencer for an iterative AES encryption
// datapath. The registered round state (state_out) feeds an external
// SubBytes -> ShiftRows -> mixcolumn chain. Each accepted round XORs the
// returned data with the round key supplied by the key schedule.
//
// The data source for each round depends on the round index r = key_round:
//   r == 0         : latched plaintext (initial AddRoundKey)
//   1 <= r <= NR-1 : mcl_in (column-mixed state)
//   r == NR        : sr_in  (final round skips MixColumns)
//
// Parameters
//   NR     number of rounds (10, 12 or 14)
//   RND_W  width of the round counter, 2**RND_W > NR
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   start       in   begin a block; sampled only while idle
//   plaintext   in   128-bit input block, latched when start is accepted
//   mcl_in      in   mixcolumn output derived from state_out
//   sr_in       in   ShiftRows output derived from state_out (final round)
//   round_key   in   round key for index key_round
//   key_valid   in   round_key is valid this cycle; a round is accepted
//   key_req     out  key for key_round is requested
//   key_round   out  index of the requested round key, 0..NR
//   state_out   out  registered round state
//   busy        out  high while a block is in progress
//   done        out  one-cycle pulse, ciphertext has just been updated
//   ciphertext  out  final state, held until the next completion
//
// Byte order: [127:120] is byte 0 (row 0, column 0); columns are 32-bit
// groups, MSB first. The XOR is bitwise, so the order only matters to the
// surrounding chain.
// -----------------------------------------------------------------------------
module aes_round_key_stage #(
  parameter int NR    = 14,
  parameter int RND_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [127:0]     plaintext,
  input  logic [127:0]     mcl_in,
  input  logic [127:0]     sr_in,
  input  logic [127:0]     round_key,
  input  logic             key_valid,
  output logic             key_req,
  output logic [RND_W-1:0] key_round,
  output logic [127:0]     state_out,
  output logic             busy,
  output logic             done,
  output logic [127:0]     ciphertext
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NR);

  state_t       state_q;
  state_t       state_d;
  logic [127:0] pt_q;
  logic [127:0] round_src;
  logic [127:0] round_val;
  logic         first_round;
  logic         last_round;
  logic         accept;

  assign first_round = (key_round == '0);
  assign last_round  = (key_round == LAST_ROUND);

  // A round completes on any RUN edge where the key schedule delivers;
  // without key_valid everything holds, however long the stall lasts.
  assign accept = (state_q == RUN) && key_valid;

  // Round data source. mcl_in/sr_in are combinational from state_out, so
  // the only register in the round loop is state_out itself.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    round_src = mcl_in;
    if (first_round) begin
      round_src = pt_q;
    end else if (last_round) begin
      round_src = sr_in;
    end
  end

  assign round_val = round_src ^ round_key;

  // ---------------------------------------------------------------------------
  // FSM: next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    key_req = 1'b0;
    case (state_q)
      IDLE: begin
        // The accepting edge only latches the block; round 0 comes after.
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        key_req = 1'b1;
        if (key_valid && last_round) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: plaintext latch, round counter, round state, result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pt_q       <= '0;
      key_round  <= '0;
      state_out  <= '0;
      ciphertext <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      // start while busy is ignored: the latch is only written from IDLE.
      if ((state_q == IDLE) && start) begin
        pt_q      <= plaintext;
        key_round <= '0;
      end

      if (accept) begin
        state_out <= round_val;
        if (last_round) begin
          // Counter returns to 0 here, so it never exceeds NR or wraps.
          ciphertext <= round_val;
          done       <= 1'b1;
          key_round  <= '0;
        end else begin
          key_round <= key_round + RND_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_round_key_stage.sv
// -----------------------------------------------------------------------------
// tb_aes_round_key_stage
//
// Directed bench for aes_round_key_stage. Two instances are built: NR = 14
// (AES-256) and NR = 10 (AES-128). The bench models the external
// SubBytes/ShiftRows/mixcolumn chain and the key schedule, so the stage
// closes its round loop exactly as in the real datapath. Expected results
// are the published FIPS-197 vectors; the second block of the back-to-back
// scenario is checked against a behavioural AES reference.
// -----------------------------------------------------------------------------
module tb_aes_round_key_stage;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_ALT  = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam logic [255:0] KEY256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] ROUND0  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_checks = 0;
  int n_fail   = 0;

  logic         clk = 1'b0;
  logic         reset;
  logic         start14;
  logic         start10;
  logic [127:0] plaintext;
  logic         key_valid;

  logic [127:0] sched14 [0:15];
  logic [127:0] sched10 [0:15];

  // NR = 14 instance
  logic [127:0] mcl14, sr14, rk14, so14, ct14;
  logic [3:0]   kr14;
  logic         kreq14, busy14, done14;

  // NR = 10 instance
  logic [127:0] mcl10, sr10, rk10, so10, ct10;
  logic [3:0]   kr10;
  logic         kreq10, busy10, done10;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // AES helper functions (environment model)
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]  w [0:63];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [127:0] k;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      k = '0;
      if (r <= nr) k = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (nr == 14) sched14[r] = k;
      else          sched10[r] = k;
    end
  endtask

  function automatic logic [127:0] rk_of(input int r, input int nr);
    return (nr == 14) ? sched14[4'(r)] : sched10[4'(r)];
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
    logic [127:0] s;
    s = pt ^ rk_of(0, nr);
    for (int r = 1; r < nr; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk_of(r, nr);
    return shift_rows(sub_bytes(s)) ^ rk_of(nr, nr);
  endfunction

  // External round chain and key schedule responding to the stages
  assign sr14  = shift_rows(sub_bytes(so14));
  assign mcl14 = mix_columns(sr14);
  assign rk14  = sched14[kr14];
  assign sr10  = shift_rows(sub_bytes(so10));
  assign mcl10 = mix_columns(sr10);
  assign rk10  = sched10[kr10];

  aes_round_key_stage #(.NR(14), .RND_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start14),
    .plaintext  (plaintext),
    .mcl_in     (mcl14),
    .sr_in      (sr14),
    .round_key  (rk14),
    .key_valid  (key_valid),
    .key_req    (kreq14),
    .key_round  (kr14),
    .state_out  (so14),
    .busy       (busy14),
    .done       (done14),
    .ciphertext (ct14)
  );

  aes_round_key_stage #(.NR(10), .RND_W(4)) dut128 (
    .clk        (clk),
    .reset      (reset),
    .start      (start10),
    .plaintext  (plaintext),
    .mcl_in     (mcl10),
    .sr_in      (sr10),
    .round_key  (rk10),
    .key_valid  (key_valid),
    .key_req    (kreq10),
    .key_round  (kr10),
    .state_out  (so10),
    .busy       (busy10),
    .done       (done10),
    .ciphertext (ct10)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers (NR = 14 instance)
  // ---------------------------------------------------------------------------
  // One clock edge, sampled 1 time unit later, with the range and
  // single-pulse invariants checked on every cycle.
  task automatic step14();
    logic prev_done;
    prev_done = done14;
    @(posedge clk);
    #1;
    n_checks++;
    if (kr14 > 4'd14) begin
      n_fail++;
      $display("FAIL key_round_range: got %0d, limit 14", kr14);
    end
    n_checks++;
    if (prev_done && done14) begin
      n_fail++;
      $display("FAIL done_single_pulse: done high on two consecutive cycles");
    end
  endtask

  task automatic start_block14(input logic [127:0] pt);
    plaintext = pt;
    start14   = 1'b1;
    step14();
    start14   = 1'b0;
  endtask

  // Cycle 1 is the cycle after the start edge; cyc is the cycle in which
  // done is first seen.
  task automatic run_to_done14(output int cyc);
    cyc = 1;
    while (!done14 && cyc < 60) begin
      step14();
      cyc++;
    end
    n_checks++;
    if (!done14) begin
      n_fail++;
      $display("FAIL done_timeout14: no done within %0d cycles", cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy14 !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy14); end
    n_checks++; if (done14 !== 1'b0)    begin n_fail++; $display("FAIL rst_done: got %b want 0", done14); end
    n_checks++; if (kreq14 !== 1'b0)    begin n_fail++; $display("FAIL rst_key_req: got %b want 0", kreq14); end
    n_checks++; if (kr14 !== 4'd0)      begin n_fail++; $display("FAIL rst_key_round: got %0d want 0", kr14); end
    n_checks++; if (so14 !== 128'h0)    begin n_fail++; $display("FAIL rst_state: got %h want 0", so14); end
    n_checks++; if (ct14 !== 128'h0)    begin n_fail++; $display("FAIL rst_ct: got %h want 0", ct14); end
    reset     = 1'b0;
    key_valid = 1'b1;

    start_block14(PT_FIPS);
    n = 0;
    while (kr14 != 4'd5 && n < 20) begin
      step14();
      n++;
    end
    n_checks++;
    if (kr14 !== 4'd5 || busy14 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_reach_round5: got round %0d busy %b want 5/1", kr14, busy14);
    end

    // Asynchronous assertion between edges
    #3 reset = 1'b1;
    #1;
    n_checks++; if (so14 !== 128'h0) begin n_fail++; $display("FAIL rst_async_state: got %h want 0", so14); end
    n_checks++; if (kr14 !== 4'd0)   begin n_fail++; $display("FAIL rst_async_round: got %0d want 0", kr14); end
    n_checks++; if (busy14 !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", busy14); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++; if (busy14 !== 1'b0) begin n_fail++; $display("FAIL rst_next_busy: got %b want 0", busy14); end
    n_checks++; if (kr14 !== 4'd0)   begin n_fail++; $display("FAIL rst_next_round: got %0d want 0", kr14); end
    n_checks++; if (so14 !== 128'h0) begin n_fail++; $display("FAIL rst_next_state: got %h want 0", so14); end
    repeat (4) begin
      step14();
      n_checks++;
      if (done14 !== 1'b0 || busy14 !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_done: got done %b busy %b want 0/0", done14, busy14);
      end
    end
  endtask

  task automatic test_fips256();
    int cyc;
    key_valid = 1'b1;
    start_block14(PT_FIPS);
    // The start edge is not a round
    n_checks++; if (kr14 !== 4'd0)   begin n_fail++; $display("FAIL f256_start_round: got %0d want 0", kr14); end
    n_checks++; if (so14 !== 128'h0) begin n_fail++; $display("FAIL f256_start_state: got %h want 0", so14); end
    n_checks++; if (busy14 !== 1'b1 || kreq14 !== 1'b1) begin
      n_fail++; $display("FAIL f256_start_busy: got busy %b key_req %b want 1/1", busy14, kreq14);
    end
    step14();
    n_checks++; if (so14 !== ROUND0) begin n_fail++; $display("FAIL f256_round0: got %h want %h", so14, ROUND0); end
    n_checks++; if (kr14 !== 4'd1)   begin n_fail++; $display("FAIL f256_round0_idx: got %0d want 1", kr14); end
    run_to_done14(cyc);
    cyc++;
    n_checks++; if (cyc !== 16)     begin n_fail++; $display("FAIL f256_latency: got %0d want 16", cyc); end
    n_checks++; if (ct14 !== CT256) begin n_fail++; $display("FAIL f256_ct: got %h want %h", ct14, CT256); end
    n_checks++; if (so14 !== CT256) begin n_fail++; $display("FAIL f256_state_final: got %h want %h", so14, CT256); end
    n_checks++; if (busy14 !== 1'b0 || kr14 !== 4'd0) begin
      n_fail++; $display("FAIL f256_idle_after: got busy %b round %0d want 0/0", busy14, kr14);
    end
    step14();
    n_checks++; if (done14 !== 1'b0 || ct14 !== CT256) begin
      n_fail++; $display("FAIL f256_hold: got done %b ct %h want 0/%h", done14, ct14, CT256);
    end
  endtask

  task automatic test_stall();
    int           cyc;
    int           stalls [0:15];
    logic [127:0] so_snap;
    logic [3:0]   kr_snap;
    bit           stalling;
    for (int i = 0; i < 16; i++) stalls[i] = 0;
    key_valid = 1'b1;
    start_block14(PT_FIPS);
    cyc = 1;
    while (!done14 && cyc < 60) begin
      stalling = busy14 && (kr14 == 4'd0 || kr14 == 4'd7 || kr14 == 4'd14) && stalls[kr14] < 3;
      if (stalling) begin
        key_valid = 1'b0;
        stalls[kr14]++;
      end else begin
        key_valid = 1'b1;
      end
      so_snap = so14;
      kr_snap = kr14;
      step14();
      cyc++;
      if (stalling) begin
        n_checks++; if (so14 !== so_snap) begin n_fail++; $display("FAIL stall_state: got %h want %h", so14, so_snap); end
        n_checks++; if (kr14 !== kr_snap) begin n_fail++; $display("FAIL stall_round: got %0d want %0d", kr14, kr_snap); end
      end
    end
    key_valid = 1'b1;
    n_checks++; if (!done14)        begin n_fail++; $display("FAIL stall_timeout: no done by cycle %0d", cyc); end
    n_checks++; if (cyc !== 25)     begin n_fail++; $display("FAIL stall_latency: got %0d want 25", cyc); end
    n_checks++; if (ct14 !== CT256) begin n_fail++; $display("FAIL stall_ct: got %h want %h", ct14, CT256); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit p3, p9;
    p3 = 1'b0;
    p9 = 1'b0;
    key_valid = 1'b1;
    start_block14(PT_FIPS);
    cyc = 1;
    while (!done14 && cyc < 60) begin
      start14 = 1'b0;
      if (kr14 == 4'd3 && !p3) begin
        start14 = 1'b1; plaintext = PT_ALT; p3 = 1'b1;
      end else if (kr14 == 4'd9 && !p9) begin
        start14 = 1'b1; plaintext = ~PT_ALT; p9 = 1'b1;
      end
      step14();
      cyc++;
    end
    start14   = 1'b0;
    plaintext = PT_FIPS;
    n_checks++; if (!(p3 && p9))    begin n_fail++; $display("FAIL ign_pulses: got p3 %b p9 %b want 1/1", p3, p9); end
    n_checks++; if (cyc !== 16)     begin n_fail++; $display("FAIL ign_latency: got %0d want 16", cyc); end
    n_checks++; if (ct14 !== CT256) begin n_fail++; $display("FAIL ign_ct: got %h want %h", ct14, CT256); end
    step14();
    n_checks++; if (busy14 !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got busy %b want 0", busy14); end
  endtask

  task automatic test_back_to_back();
    int           cyc;
    int           n_done;
    logic [127:0] exp2;
    exp2      = aes_ref(128'h0, 14);
    key_valid = 1'b1;
    start_block14(PT_FIPS);
    run_to_done14(cyc);
    n_done = done14 ? 1 : 0;
    n_checks++; if (ct14 !== CT256) begin n_fail++; $display("FAIL b2b_ct1: got %h want %h", ct14, CT256); end

    // start in the done cycle: the FSM is already idle and accepts it
    plaintext = 128'h0;
    start14   = 1'b1;
    step14();
    start14   = 1'b0;
    n_checks++; if (busy14 !== 1'b1 || done14 !== 1'b0 || kr14 !== 4'd0) begin
      n_fail++; $display("FAIL b2b_accept: got busy %b done %b round %0d want 1/0/0", busy14, done14, kr14);
    end
    cyc = 1;
    while (!done14 && cyc < 60) begin
      n_checks++;
      if (ct14 !== CT256) begin n_fail++; $display("FAIL b2b_ct1_hold: got %h want %h", ct14, CT256); end
      step14();
      cyc++;
    end
    if (done14) n_done++;
    n_checks++; if (cyc !== 16)    begin n_fail++; $display("FAIL b2b_latency: got %0d want 16", cyc); end
    n_checks++; if (ct14 !== exp2) begin n_fail++; $display("FAIL b2b_ct2: got %h want %h", ct14, exp2); end
    repeat (3) begin
      step14();
      if (done14) n_done++;
    end
    n_checks++; if (n_done !== 2)  begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
    n_checks++; if (ct14 !== exp2) begin n_fail++; $display("FAIL b2b_ct2_hold: got %h want %h", ct14, exp2); end
  endtask

  task automatic test_aes128();
    int cyc;
    key_valid = 1'b1;
    plaintext = PT_FIPS;
    start10   = 1'b1;
    @(posedge clk);
    #1;
    start10   = 1'b0;
    n_checks++; if (busy10 !== 1'b1 || kr10 !== 4'd0) begin
      n_fail++; $display("FAIL a128_start: got busy %b round %0d want 1/0", busy10, kr10);
    end
    cyc = 1;
    while (!done10 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      n_checks++;
      if (kr10 > 4'd10) begin n_fail++; $display("FAIL a128_round_range: got %0d limit 10", kr10); end
      if (cyc == 2) begin
        n_checks++;
        if (so10 !== ROUND0) begin n_fail++; $display("FAIL a128_round0: got %h want %h", so10, ROUND0); end
      end
    end
    n_checks++; if (cyc !== 12)     begin n_fail++; $display("FAIL a128_latency: got %0d want 12", cyc); end
    n_checks++; if (ct10 !== CT128) begin n_fail++; $display("FAIL a128_ct: got %h want %h", ct10, CT128); end
    @(posedge clk);
    #1;
    n_checks++; if (done10 !== 1'b0 || busy10 !== 1'b0) begin
      n_fail++; $display("FAIL a128_idle: got done %b busy %b want 0/0", done10, busy10);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    start14   = 1'b0;
    start10   = 1'b0;
    key_valid = 1'b0;
    plaintext = '0;
    expand_key(KEY256, 8, 14);
    expand_key(KEY128, 4, 10);

    test_reset();
    test_fips256();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_aes128();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
